// File: rtl/moving_avg_win.sv
// Moving-average filter over a power-of-two window of signed samples.
// The running sum is updated with one add and one subtract per accepted sample.
module moving_avg_win #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned LOG2_DEPTH = 2,
    parameter int unsigned ROUND      = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clr,
    input  logic                                in_valid,
    input  logic        [DATA_W-1:0]            in_data,
    input  logic                                mode,
    output logic                                out_valid,
    output logic signed [DATA_W+LOG2_DEPTH-1:0] out_data,
    output logic                                full,
    output logic        [LOG2_DEPTH:0]          fill_count
);

    localparam int unsigned DEPTH = 1 << LOG2_DEPTH;
    localparam int unsigned ACC_W = DATA_W + LOG2_DEPTH;

    localparam logic signed [ACC_W:0] HALF =
        (ACC_W+1)'((ROUND != 0) ? (1 << (LOG2_DEPTH - 1)) : 0);
    localparam logic signed [ACC_W:0] AVG_MAX = (ACC_W+1)'((1 << (DATA_W - 1)) - 1);
    localparam logic [LOG2_DEPTH:0]   FILL_MAX = (LOG2_DEPTH+1)'(DEPTH);

    logic        [DATA_W-1:0]     r_buf [DEPTH];
    logic signed [ACC_W-1:0]      r_acc;
    logic        [LOG2_DEPTH-1:0] r_wr_ptr;
    logic        [LOG2_DEPTH:0]   r_fill;
    logic signed [ACC_W-1:0]      r_out_data;
    logic                         r_out_valid;

    logic        [DATA_W-1:0]     w_old;
    logic signed [ACC_W-1:0]      w_in_ext;
    logic signed [ACC_W-1:0]      w_old_ext;
    logic signed [ACC_W-1:0]      w_new_acc;
    logic signed [ACC_W:0]        w_rnd;
    logic signed [ACC_W:0]        w_shift;
    logic        [DATA_W-1:0]     w_avg;
    logic signed [ACC_W-1:0]      w_avg_ext;
    logic signed [ACC_W-1:0]      w_result;

    assign w_old     = r_buf[r_wr_ptr];
    assign w_in_ext  = {{LOG2_DEPTH{in_data[DATA_W-1]}}, in_data};
    assign w_old_ext = {{LOG2_DEPTH{w_old[DATA_W-1]}}, w_old};
    assign w_new_acc = r_acc + w_in_ext - w_old_ext;

    // One extra bit so the rounding offset cannot wrap the largest positive sum.
    assign w_rnd     = {w_new_acc[ACC_W-1], w_new_acc} + HALF;
    assign w_shift   = w_rnd >>> LOG2_DEPTH;
    assign w_avg     = (w_shift > AVG_MAX) ? AVG_MAX[DATA_W-1:0] : w_shift[DATA_W-1:0];
    assign w_avg_ext = {{LOG2_DEPTH{w_avg[DATA_W-1]}}, w_avg};
    assign w_result  = mode ? w_new_acc : w_avg_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_buf[i] <= '0;
            end
            r_acc       <= '0;
            r_wr_ptr    <= '0;
            r_fill      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (clr) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_buf[i] <= '0;
            end
            r_acc       <= '0;
            r_wr_ptr    <= '0;
            r_fill      <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_buf[r_wr_ptr] <= in_data;
                // Pointer is exactly LOG2_DEPTH bits, so it wraps naturally.
                r_wr_ptr        <= r_wr_ptr + LOG2_DEPTH'(1);
                r_acc           <= w_new_acc;
                r_out_data      <= w_result;
                if (r_fill != FILL_MAX) begin
                    r_fill <= r_fill + (LOG2_DEPTH+1)'(1);
                end
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign fill_count = r_fill;
    assign full       = (r_fill == FILL_MAX);

endmodule
